// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the WB stage / MDU and the register-file write-port arbiter.
interface wb_port_arbiter_if;
  logic        i_con_regwriteW;
  logic [4:0]  i_addr_writeregW;
  logic [31:0] i_data_resultW;
  logic        i_con_mduvalid;
  logic [4:0]  i_addr_mdu;
  logic [31:0] i_data_mdu;
  logic        o_con_mduready;
  logic        o_con_regwrite;
  logic [4:0]  o_addr_writereg;
  logic [31:0] o_data_writereg;
  logic        o_con_stallW;
  logic [4:0]  i_addr_checkD;
  logic        o_con_pendhit;

  modport slave (
    input  i_con_regwriteW, i_addr_writeregW, i_data_resultW,
    input  i_con_mduvalid, i_addr_mdu, i_data_mdu, i_addr_checkD,
    output o_con_mduready, o_con_regwrite, o_addr_writereg, o_data_writereg,
    output o_con_stallW, o_con_pendhit
  );

  modport master (
    output i_con_regwriteW, i_addr_writeregW, i_data_resultW,
    output i_con_mduvalid, i_addr_mdu, i_data_mdu, i_addr_checkD,
    input  o_con_mduready, o_con_regwrite, o_addr_writereg, o_data_writereg,
    input  o_con_stallW, o_con_pendhit
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and a FIFO of MDU results; grant registered (1 cycle).
// Optional pending-write comparator on o_con_pendhit is built when WB_ARB_PENDHIT_EN is defined.
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_NORMAL, S_FORCE} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        starve_q, starve_d;
  logic [3:0]        starve_inc;
  logic [4:0]        fifo_addr_q [DEPTH];
  logic [4:0]        fifo_addr_d [DEPTH];
  logic [31:0]       fifo_data_q [DEPTH];
  logic [31:0]       fifo_data_d [DEPTH];
  logic              regwrite_q, regwrite_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic pipe_req;
  logic fifo_nonempty;
  logic mduready;
  logic mdu_acc;
  logic enq;
  logic deq;

  assign pipe_req      = bus.i_con_regwriteW && (bus.i_addr_writeregW != 5'd0);
  assign fifo_nonempty = (count_q != '0);
  // Ready comes from the registered count only, so a full FIFO refuses even while it drains.
  assign mduready      = !i_rst && (count_q < CNT_W'(DEPTH));
  assign mdu_acc       = bus.i_con_mduvalid && mduready;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    starve_d    = starve_q;
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    regwrite_d  = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    deq         = 1'b0;
    starve_inc  = starve_q + 4'd1;

    if (state_q == S_FORCE) begin
      // The stalled pipe write is re-presented next cycle, so it is ignored here.
      state_d = S_NORMAL;
      deq     = fifo_nonempty;
    end else if (pipe_req) begin
      regwrite_d = 1'b1;
      waddr_d    = bus.i_addr_writeregW;
      wdata_d    = bus.i_data_resultW;
      if (fifo_nonempty) begin
        starve_d = starve_inc;
        if (starve_inc == 4'(STARVE_MAX)) begin
          state_d = S_FORCE;
        end
      end
    end else begin
      deq = fifo_nonempty;
    end

    if (deq) begin
      regwrite_d = 1'b1;
      waddr_d    = fifo_addr_q[rd_ptr_q];
      wdata_d    = fifo_data_q[rd_ptr_q];
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
    end
    if (deq || !fifo_nonempty) begin
      starve_d = '0;
    end

    enq = mdu_acc && (bus.i_addr_mdu != 5'd0);
    if (enq) begin
      fifo_addr_d[wr_ptr_q] = bus.i_addr_mdu;
      fifo_data_d[wr_ptr_q] = bus.i_data_mdu;
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_NORMAL;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
    fifo_addr_q <= fifo_addr_d;
    fifo_data_q <= fifo_data_d;
  end

  assign bus.o_con_mduready  = mduready;
  assign bus.o_con_regwrite  = regwrite_q;
  assign bus.o_addr_writereg = waddr_q;
  assign bus.o_data_writereg = wdata_q;
  assign bus.o_con_stallW    = (state_q == S_FORCE);

`ifdef WB_ARB_PENDHIT_EN
  logic pendhit;

  // A slot is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    logic [PTR_W-1:0] off;
    pendhit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) && (fifo_addr_q[i] == bus.i_addr_checkD)) begin
        pendhit = 1'b1;
      end
    end
    if (enq && (bus.i_addr_mdu == bus.i_addr_checkD)) begin
      pendhit = 1'b1;
    end
    if (bus.i_addr_checkD == 5'd0) begin
      pendhit = 1'b0;
    end
  end

  assign bus.o_con_pendhit = pendhit;
`else
  logic unused_checkd;
  assign unused_checkd     = ^bus.i_addr_checkD;
  assign bus.o_con_pendhit = 1'b0;
`endif
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Register-file write-port controller for the ARC MIPS core. It shares the single register-file write port between the pipeline writeback stage (the WB result-mux output) and a long-latency multiply/divide unit (MDU). MDU results are held in a small FIFO, and the pipeline stalls only when queued results starve. The block sits between the WB stage and the register file, and drives the registered write port.

## Interface
- DEPTH, 2: MDU result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4: consecutive starved cycles before a forced drain (≥1, ≤15)

Clocking and reset: one clock; reset is synchronous and active-high.

- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_con_regwriteW  in  1  pipeline WB write enable
- i_addr_writeregW  in  5  pipeline WB destination register
- i_data_resultW  in  32  pipeline WB result
- i_con_mduvalid  in  1  MDU result valid
- i_addr_mdu  in  5  MDU destination register
- i_data_mdu  in  32  MDU result
- o_con_mduready  out  1  FIFO can accept an MDU result
- o_con_regwrite  out  1  register-file write enable (registered)
- o_addr_writereg  out  5  register-file write address (registered)
- o_data_writereg  out  32  register-file write data (registered)
- o_con_stallW  out  1  hold the WB stage this cycle
- i_addr_checkD  in  5  decode-stage source register to check for a pending write
- o_con_pendhit  out  1  i_addr_checkD has a queued MDU write

## Operation
- **Pipeline request:** a pipe request exists when i_con_regwriteW=1 and i_addr_writeregW≠0. Writes to $0 are dropped.
- **MDU handshake:** an MDU result is accepted when i_con_mduvalid && o_con_mduready.
  - An accepted result with i_addr_mdu=0 is consumed and discarded, not enqueued.
  - o_con_mduready = !i_rst && (count < DEPTH). It is computed from the registered count, so a full FIFO refuses a result even in a cycle where it dequeues.
- **FSM states:**
  - S_NORMAL: a pipe request is granted; otherwise, if the FIFO is non-empty, the FIFO head is granted and dequeued. o_con_stallW=0.
  - S_FORCE: o_con_stallW=1. The FIFO head is granted and dequeued. Pipe inputs are ignored, because the pipeline re-presents the same WB instruction next cycle. Next state is S_NORMAL.
- **Starvation counter** (4 bits):
  - Cleared on any dequeue, and whenever the FIFO is empty.
  - Incremented in each S_NORMAL cycle where the FIFO is non-empty and the pipe is granted.
  - When the incremented value equals STARVE_MAX, the next state is S_FORCE.
- **Ordering:** within the FIFO, first in, first out.
- **Simultaneous events:**
  - An enqueue and dequeue in the same cycle keep count unchanged.
  - A result enqueued into an empty FIFO is not grantable until the next cycle.
- **Reset:** the FIFO is flushed, count=0, starve counter=0, state=S_NORMAL. Queued MDU results are lost, and reset mid-drain discards them.
- **Arithmetic:** FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Reset values: o_con_regwrite=0, o_addr_writereg=0, o_data_writereg=0, o_con_stallW=0, o_con_mduready=0 while i_rst=1, o_con_pendhit=0.
- The grant is registered, so the register-file write occurs 1 cycle after the request cycle.
- With no grant, o_con_regwrite=0 and the address and data outputs hold their previous values.
- MDU worst-case latency from acceptance to write is bounded by queue position × (STARVE_MAX+1) + 1 cycles.
- o_con_stallW is a decode of the state register, with no combinational path from inputs.
- o_con_pendhit is combinational from i_addr_checkD, the valid FIFO entries, and the incoming accepted MDU address.

## Configuration
- WB_ARB_PENDHIT_EN defined: the pending-write comparator is built. o_con_pendhit=1 when i_addr_checkD≠0 and it matches a valid FIFO entry, or the MDU address being accepted this cycle.
- Not defined: no comparators are built, o_con_pendhit is tied 0, and i_addr_checkD is unused. Hazard handling then relies on the MDU busy stall.

## Test plan
- Reset, then a pipe write of $5=0x1234 in cycle 2 → o_con_regwrite=1, addr=5, data=0x1234 in cycle 3; a pipe write to $0 → o_con_regwrite stays 0.
- Pipe idle, MDU sends $8=0xAAAA → accepted; the write of $8 appears 2 cycles later, with count back to 0.
- Pipe writes every cycle and the MDU enqueues $9=0x55 (STARVE_MAX=4) → after 4 starved cycles, o_con_stallW=1 for exactly one cycle, and $9 is written the following cycle; the stalled pipe write is written next.
- Two MDU results with DEPTH=2 while the pipe is busy → o_con_mduready=0; a third valid is held until a dequeue, and FIFO order is preserved.
- Assert i_rst with 2 entries queued → the next cycle has count=0, o_con_mduready=1 after reset, and no queued write ever appears.
- With WB_ARB_PENDHIT_EN, queue $12 and drive i_addr_checkD=12 → o_con_pendhit=1; set i_addr_checkD=0 or 13 → 0; after $12 drains → 0.
